// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback, 2-5 cycles per instruction.
// Memory states hold until mem_ready; all outputs forced low while rst is asserted.
module mc_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            MemtoReg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_ctrl,
  output logic [1:0]      pc_source,
  output logic            instr_done,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] alu_r;
  logic       funct_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    alu_r    = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_r = ALU_ADD;
      FN_SUB:  alu_r = ALU_SUB;
      FN_AND:  alu_r = ALU_AND;
      FN_OR:   alu_r = ALU_OR;
      FN_SLT:  alu_r = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = ST_W'(state_q);

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH only needs the compare.
        alu_src_b = 2'b11;
        if (op == OP_LW || op == OP_SW)       state_d = S_MEM_ADDR;
        else if (op == OP_RTYPE && funct_ok)  state_d = S_R_EXEC;
        else if (op == OP_BEQ)                state_d = S_BRANCH;
        else if (op == OP_J)                  state_d = S_JUMP;
        else if (op == OP_ADDI)               state_d = S_I_EXEC;
        else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = alu_r;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_source  = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks everything combinationally so an abort has no trailing side effects.
    if (!rst) begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      MemtoReg   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      pc_source  = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
      state      = '0;
    end
  end

endmodule
